// File: rtl/output_backprop.sv
// Purpose : output-layer weight update, w[k] += (err * h[k]) >>> LR_SHIFT, one weight per cycle.
// Latency : en_i sampled at edge N, weights updated at edges N+1..N+8, b_end_o high the cycle after N+8.
// Backpress: none; en_i while busy is dropped (no queuing). Macro BP_SATURATE_EN selects clamping over wrap.
module output_backprop #(
  parameter int LR_SHIFT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        zero_weight_reset_i,
  input  logic [22:0] final_i,
  input  logic [3:0]  target_i,
  input  logic [79:0] hidden_i,
  input  logic [63:0] w_i,
  output logic [63:0] w_o,
  output logic        busy_o,
  output logic        b_end_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic signed [23:0]      err_q, err_d;
  logic [7:0][9:0]         hid_q, hid_d;
  logic [7:0][7:0]         w_q, w_d;

  // Datapath for the weight currently addressed by k.
  logic [9:0]              h_sel;
  logic [7:0]              w_sel;
  logic signed [34:0]      err_x;
  logic signed [34:0]      h_x;
  logic signed [34:0]      prod;
  logic signed [34:0]      prod_sh;
  logic signed [35:0]      sum;
  logic [7:0]              w_new;

  // Select operands, form the 35-bit product, floor-shift and widen to 36 bits.
  always_comb begin
    h_sel   = hid_q[k_q];
    w_sel   = w_q[k_q];
    err_x   = {{11{err_q[23]}}, err_q};
    h_x     = {25'd0, h_sel};
    prod    = err_x * h_x;
    prod_sh = prod >>> LR_SHIFT;
    sum     = {prod_sh[34], prod_sh} + {{28{w_sel[7]}}, w_sel};
  end

`ifdef BP_SATURATE_EN
  // Clamp the widened sum into the signed 8-bit range.
  always_comb begin
    if (sum > 36'sd127) begin
      w_new = 8'h7F;
    end else if (sum < -36'sd128) begin
      w_new = 8'h80;
    end else begin
      w_new = sum[7:0];
    end
  end
`else
  // Upper sum bits are discarded on purpose: two's-complement wrap keeps only the low byte.
  logic sum_hi_unused;
  assign sum_hi_unused = ^sum[35:8];

  // Wrap: the low byte of the sum is the new weight.
  always_comb begin
    w_new = sum[7:0];
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath next values and status outputs; weight clear outranks everything.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    hid_d   = hid_q;
    w_d     = w_q;
    busy_o  = (state_q != IDLE);
    b_end_o = (state_q == DONE);

    if (zero_weight_reset_i) begin
      state_d = IDLE;
      k_d     = 3'd0;
      w_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) begin
            w_d     = w_i;
            hid_d   = hidden_i;
            err_d   = $signed({20'd0, target_i}) - $signed({1'b0, final_i});
            k_d     = 3'd0;
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          w_d[k_q] = w_new;
          k_d      = k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath registers: index, captured error, hidden activations and weights.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      k_q   <= 3'd0;
      err_q <= '0;
      hid_q <= '0;
      w_q   <= '0;
    end else begin
      k_q   <= k_d;
      err_q <= err_d;
      hid_q <= hid_d;
      w_q   <= w_d;
    end
  end

  assign w_o = w_q;

endmodule

// File: tb/tb_output_backprop.sv
// Bench for output_backprop: directed scenarios plus randomized passes against an arithmetic reference model.
// Expected weights are computed with integer arithmetic (floor division, explicit clamp or modulo).
// Honours BP_SATURATE_EN the same way the design does.
module tb_output_backprop;

  localparam int LR = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        zr = 1'b0;
  logic [22:0] fin = '0;
  logic [3:0]  tgt = '0;
  logic [79:0] hid = '0;
  logic [63:0] win = '0;
  logic [63:0] wout;
  logic        busy;
  logic        bend;

  int checks = 0;
  int errors = 0;

  logic [63:0] res;
  logic [63:0] res2;
  logic [63:0] rw;
  logic [79:0] rh;
  logic [3:0]  rt;
  logic [22:0] rf;
  logic [7:0]  exp_b0;

  always #5 clk = ~clk;

  output_backprop #(.LR_SHIFT(LR)) dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .en_i                (en),
    .zero_weight_reset_i (zr),
    .final_i             (fin),
    .target_i            (tgt),
    .hidden_i            (hid),
    .w_i                 (win),
    .w_o                 (wout),
    .busy_o              (busy),
    .b_end_o             (bend)
  );

  // Reference update of a single weight: floor((err*h)/2^LR) added to w, then clamp or wrap.
  function automatic logic [7:0] model_upd(input logic [7:0] w, input logic [9:0] h, input int err);
    longint p, q, s, den;
    den = longint'(1) << LR;
    p   = longint'(err) * longint'(h);
    if (p >= 0) q = p / den;
    else        q = -((-p + den - 1) / den);
    s = longint'($signed(w)) + q;
`ifdef BP_SATURATE_EN
    if (s > 127)       s = 127;
    else if (s < -128) s = -128;
`endif
    s = ((s % 256) + 256) % 256;
    return s[7:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  // One full pass; with noise, en_i and all data inputs are scrambled while the pass runs.
  task automatic run_pass(input logic [63:0] w, input logic [79:0] h, input logic [3:0] t,
                          input logic [22:0] f, input bit noise, output logic [63:0] r);
    logic [63:0] cur;
    int          err;
    err = int'(t) - int'(f);
    @(negedge clk);
    win = w; hid = h; tgt = t; fin = f; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("capture_w", wout, w);
    chk1("busy_start", busy, 1'b1);
    chk1("bend_start", bend, 1'b0);
    cur = w;
    for (int j = 0; j < 8; j++) begin
      if (noise && j >= 2 && j <= 4) begin
        en  = 1'b1;
        win = {$urandom, $urandom};
        hid = {16'($urandom), $urandom, $urandom};
        tgt = 4'($urandom);
        fin = 23'($urandom);
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
      cur[8*j +: 8] = model_upd(w[8*j +: 8], h[10*j +: 10], err);
      chk("w_mid", wout, cur);
      chk1("busy_mid", busy, 1'b1);
      chk1("bend_mid", bend, j == 7);
    end
    en = 1'b0;
    @(negedge clk);
    chk1("bend_after", bend, 1'b0);
    chk1("busy_after", busy, 1'b0);
    chk("w_after", wout, cur);
    r = cur;
  endtask

  initial begin
    // Reset state while rst is held low.
    #1;
    chk("rst_w", wout, 64'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_bend", bend, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_w", wout, 64'd0);

    // All weights 1, h 256, err 4: each weight gains 4.
    run_pass({8{8'h01}}, {8{10'd256}}, 4'd4, 23'd0, 1'b0, res);
    chk("dir_all05", res, {8{8'h05}});

    // Positive overflow of weight 0.
    run_pass({56'd0, 8'h7F}, {70'd0, 10'd1023}, 4'd15, 23'd0, 1'b0, res);
`ifdef BP_SATURATE_EN
    exp_b0 = 8'h7F;
`else
    exp_b0 = 8'hBA;
`endif
    chk("dir_pos_ovf", {56'd0, res[7:0]}, {56'd0, exp_b0});

    // Negative overflow of weight 0.
    run_pass(64'd0, {70'd0, 10'd256}, 4'd0, 23'd1000, 1'b0, res);
`ifdef BP_SATURATE_EN
    exp_b0 = 8'h80;
`else
    exp_b0 = 8'h18;
`endif
    chk("dir_neg_ovf", {56'd0, res[7:0]}, {56'd0, exp_b0});

    // Idle with en low and changing inputs: weights hold.
    win = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    chk("idle_hold", wout, res);
    chk1("idle_busy", busy, 1'b0);

    // Synchronous weight clear three edges into a pass, with en_i on the same edge.
    @(negedge clk);
    win = {8{8'h11}}; hid = {8{10'd300}}; tgt = 4'd9; fin = 23'd2; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    zr = 1'b1; en = 1'b1;
    @(negedge clk);
    zr = 1'b0; en = 1'b0;
    chk("zr_w", wout, 64'd0);
    chk1("zr_busy", busy, 1'b0);
    chk1("zr_bend", bend, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("zr_no_bend", bend, 1'b0);
      chk1("zr_no_busy", busy, 1'b0);
    end
    chk("zr_hold", wout, 64'd0);

    // Randomized passes; pass 3 re-asserts en_i and scrambles inputs mid-pass.
    for (int it = 0; it < 8; it++) begin
      rw = {$urandom, $urandom};
      rh = {16'($urandom), $urandom, $urandom};
      rt = 4'($urandom);
      rf = (it % 2 == 0) ? 23'($urandom_range(0, 40)) : 23'($urandom);
      run_pass(rw, rh, rt, rf, it == 3, res);
      if (it == 3) begin
        // Next pass starts from the updated weights.
        run_pass(res, rh, rt, rf, 1'b0, res2);
      end
    end

    // Asynchronous reset in the middle of an update pass.
    @(negedge clk);
    win = {8{8'h22}}; hid = {8{10'd512}}; tgt = 4'd7; fin = 23'd1; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_w", wout, 64'd0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_bend", bend, 1'b0);
    @(negedge clk);
    chk("arst_hold_w", wout, 64'd0);
    chk1("arst_hold_bend", bend, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("arst_release_bend", bend, 1'b0);
    run_pass({8{8'hF0}}, {8{10'd128}}, 4'd12, 23'd3, 1'b0, res);
    chk("arst_next_pass", res, {8{8'hF4}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/output_backprop.md
OUTPUT_BACKPROP -- requirements
Module: output_backprop

Interface
REQ-001 Parameter LR_SHIFT, default 8, arithmetic right-shift applied to each error*hidden product (learning rate 2^-LR_SHIFT).
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 en_i  in  1  start request, sampled only in IDLE.
REQ-005 zero_weight_reset_i  in  1  synchronous clear of weights and FSM.
REQ-006 final_i  in  23  forward-pass output, unsigned.
REQ-007 target_i  in  4  training target, unsigned.
REQ-008 hidden_i  in  80  eight unsigned 10-bit hidden activations, h[k] = bits [10k+9:10k].
REQ-009 w_i  in  64  eight signed 8-bit current weights, w[k] = bits [8k+7:8k].
REQ-010 w_o  out  64  updated weights, same packing as w_i, registered.
REQ-011 busy_o  out  1  high in LOAD-free states UPDATE and DONE.
REQ-012 b_end_o  out  1  one-cycle pulse, update pass complete.

Function
REQ-013 The FSM SHALL have states IDLE, UPDATE, DONE.
REQ-014 IDLE + en_i=1 at edge N: capture w_i and hidden_i into internal registers, capture err = {0,target_i} - {0,final_i} as 24-bit signed, clear index k to 0, go to UPDATE.
REQ-015 UPDATE, edges N+1..N+8: for k=0..7 in order, w[k] <= f(w[k] + ((err * h[k]) >>> LR_SHIFT)), one weight per cycle; k increments.
REQ-016 Product SHALL be computed as 35-bit signed (h zero-extended to 11 bits); shift is arithmetic (floor); sum computed at 36 bits before f().
REQ-017 After the k=7 update at edge N+8, state SHALL be DONE; b_end_o=1 for exactly the cycle following edge N+8; edge N+9 returns to IDLE.
REQ-018 busy_o SHALL be high from after edge N through the DONE cycle; low in IDLE.
REQ-019 en_i while busy SHALL be ignored; no queuing.
REQ-020 w_o SHALL continuously reflect the internal weight registers (partially updated values visible mid-pass).
REQ-021 zero_weight_reset_i=1 at any edge SHALL clear all weights to 0, clear k, force IDLE, suppress b_end_o; it has priority over en_i and UPDATE.
REQ-022 In IDLE without en_i, weights SHALL hold their value.

Reset
REQ-023 rst_i=0 SHALL immediately force IDLE, k=0, err=0, all weights 0, w_o=0, busy_o=0, b_end_o=0, including mid-pass.
REQ-024 After rst_i release, the first en_i SHALL start a normal pass.

Configuration
REQ-025 Macro BP_SATURATE_EN defined: f() SHALL clamp to [-128, 127].
REQ-026 BP_SATURATE_EN undefined: f() SHALL take the low 8 bits (two's-complement wrap).

Verification
REQ-027 w_i all 0x01, h all 256, target 4, final 0, en_i pulse -> w_o all 0x05, b_end_o high exactly 9 cycles after en_i sample edge.
REQ-028 w[0]=0x7F, h[0]=1023, target 15, final 0 -> w_o[7:0]=0x7F with BP_SATURATE_EN, 0xBA without.
REQ-029 w[0]=0x00, h[0]=256, target 0, final 1000 -> w_o[7:0]=0x80 with BP_SATURATE_EN, 0x18 without.
REQ-030 zero_weight_reset_i pulsed 3 cycles after start -> w_o=0, busy_o=0 next cycle, no b_end_o; en_i on same edge as zero_weight_reset_i ignored.
REQ-031 en_i re-asserted during UPDATE -> ignored, single b_end_o; second en_i after IDLE starts new pass using updated w_i.
REQ-032 rst_i asserted mid-UPDATE -> all outputs 0 asynchronously, no b_end_o, normal pass after release.
